// File: rtl/l2_cache_pkg.sv
// rtl/l2_cache_pkg.sv - shared types and constants for the N-way L2 cache
package l2_cache_pkg;
  localparam int LINE_BITS = 256;
  localparam int MASK_BITS = LINE_BITS / 8;

  typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_t;
  typedef logic [LINE_BITS-1:0] line_t;
endpackage

// File: rtl/l2_plru_tree.sv
// rtl/l2_plru_tree.sv - tree-PLRU victim walk and access update for one set
module l2_plru_tree #(
  parameter int WAYS = 4,
  localparam int WAY_BITS = $clog2(WAYS)
) (
  input  logic [WAYS-2:0]     bits_cur,
  input  logic [WAY_BITS-1:0] access_way,
  output logic [WAY_BITS-1:0] victim_way,
  output logic [WAYS-2:0]     bits_next
);
  // Heap numbering: node n has children 2n (lower half) and 2n+1 (upper half), root is 1.
  logic [WAYS-1:1]   tree_cur, tree_next;
  logic [WAY_BITS-1:0] walk;
  logic [WAY_BITS:0]   full, shifted;

  assign tree_cur  = bits_cur;
  assign bits_next = tree_next;

  // The leading 1 of the root shifts out on the last step, leaving the way number.
  always_comb begin
    walk = WAY_BITS'(1);
    for (int l = 0; l < WAY_BITS; l++)
      walk = (walk << 1) | WAY_BITS'(tree_cur[walk]);
    victim_way = walk;
  end

  always_comb begin
    tree_next = tree_cur;
    full      = {1'b1, access_way};
    shifted   = '0;
    for (int l = 0; l < WAY_BITS; l++) begin
      shifted = full >> (WAY_BITS - l - 1);
      tree_next[shifted[WAY_BITS:1]] = ~shifted[0];
    end
  end
endmodule

// File: rtl/l2_cache_nway.sv
// rtl/l2_cache_nway.sv - N-way set-associative write-back L2 cache with tree-PLRU replacement
module l2_cache_nway
  import l2_cache_pkg::*;
#(
  parameter int S_OFFSET = 5,
  parameter int S_INDEX  = 3,
  parameter int WAYS     = 4,
  localparam int S_TAG    = 32 - S_OFFSET - S_INDEX,
  localparam int NUM_SETS = 2 ** S_INDEX,
  localparam int WAY_BITS = $clog2(WAYS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic [31:0]          mem_address,
  input  logic [LINE_BITS-1:0] mem_wdata256,
  input  logic [MASK_BITS-1:0] mem_byte_enable256,
  output logic [LINE_BITS-1:0] mem_rdata256,
  output logic                 mem_resp,
  output logic                 pmem_read,
  output logic                 pmem_write,
  output logic [31:0]          pmem_address,
  output logic [LINE_BITS-1:0] pmem_wdata,
  input  logic [LINE_BITS-1:0] pmem_rdata,
  input  logic                 pmem_resp
);
  state_t state, state_next;

  logic [S_TAG-1:0] tag_arr   [WAYS][NUM_SETS];
  line_t            data_arr  [WAYS][NUM_SETS];
  logic             valid_arr [WAYS][NUM_SETS];
  logic             dirty_arr [WAYS][NUM_SETS];
  logic [WAYS-2:0]  plru_arr  [NUM_SETS];

  logic [S_TAG-1:0]    miss_tag;
  logic [S_INDEX-1:0]  miss_idx;
  logic [WAY_BITS-1:0] victim_way;

  logic [S_TAG-1:0]    req_tag;
  logic [S_INDEX-1:0]  req_idx;
  logic                req;
  logic [WAYS-1:0]     hit_vec;
  logic [WAY_BITS-1:0] hit_way, free_way, plru_way, victim_sel;
  logic                any_free, write_hit, miss_start, fill_done;
  logic [WAYS-2:0]     plru_next;
  logic                unused_offset;

  assign req_tag       = mem_address[31 -: S_TAG];
  assign req_idx       = mem_address[S_OFFSET +: S_INDEX];
  assign req           = mem_read | mem_write;
  assign unused_offset = ^mem_address[S_OFFSET-1:0];

  // Downward scan so the lowest-numbered hit/free way wins.
  always_comb begin
    hit_vec  = '0;
    hit_way  = '0;
    free_way = '0;
    any_free = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      hit_vec[w] = valid_arr[w][req_idx] && (tag_arr[w][req_idx] == req_tag);
      if (hit_vec[w]) hit_way = WAY_BITS'(w);
      if (!valid_arr[w][req_idx]) begin
        free_way = WAY_BITS'(w);
        any_free = 1'b1;
      end
    end
  end

  l2_plru_tree #(.WAYS(WAYS)) u_plru (
    .bits_cur   (plru_arr[req_idx]),
    .access_way (hit_way),
    .victim_way (plru_way),
    .bits_next  (plru_next)
  );

  assign victim_sel = any_free ? free_way : plru_way;

  always_comb begin
    state_next   = state;
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    miss_start   = 1'b0;
    fill_done    = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          if (|hit_vec) begin
            mem_resp = 1'b1;
          end else begin
            miss_start = 1'b1;
            state_next = (valid_arr[victim_sel][req_idx] && dirty_arr[victim_sel][req_idx])
                         ? WRITEBACK : FILL;
          end
        end
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_arr[victim_way][miss_idx], miss_idx, {S_OFFSET{1'b0}}};
        pmem_wdata   = data_arr[victim_way][miss_idx];
        if (pmem_resp) state_next = FILL;
      end
      FILL: begin
        pmem_read    = 1'b1;
        pmem_address = {miss_tag, miss_idx, {S_OFFSET{1'b0}}};
        if (pmem_resp) begin
          fill_done  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A simultaneous read+write lands here as a write.
  assign write_hit    = mem_resp & mem_write;
  assign mem_rdata256 = mem_resp ? data_arr[hit_way][req_idx] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      miss_tag   <= '0;
      miss_idx   <= '0;
      victim_way <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        plru_arr[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          valid_arr[w][s] <= 1'b0;
          dirty_arr[w][s] <= 1'b0;
        end
      end
    end else begin
      state <= state_next;
      if (miss_start) begin
        miss_tag   <= req_tag;
        miss_idx   <= req_idx;
        victim_way <= victim_sel;
      end
      if (fill_done) begin
        valid_arr[victim_way][miss_idx] <= 1'b1;
        dirty_arr[victim_way][miss_idx] <= 1'b0;
      end
      if (write_hit) dirty_arr[hit_way][req_idx] <= 1'b1;
      if (mem_resp) plru_arr[req_idx] <= plru_next;
    end
  end

  // Tags and data are qualified by valid, so they carry no reset.
  always_ff @(posedge clk) begin
    if (fill_done) begin
      data_arr[victim_way][miss_idx] <= pmem_rdata;
      tag_arr[victim_way][miss_idx]  <= miss_tag;
    end
    if (write_hit) begin
      for (int b = 0; b < MASK_BITS; b++)
        if (mem_byte_enable256[b])
          data_arr[hit_way][req_idx][8*b +: 8] <= mem_wdata256[8*b +: 8];
    end
  end
endmodule
